// File: rtl/sliding_window_buffer.sv
// ============================================================================
//  Module      : sliding_window_buffer
//  Description : Raster-order pixel stream to KxK sliding window. The block
//                buffers K-1 image rows in circular line buffers indexed by
//                column and flags only windows that lie fully inside the image.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sliding_window_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = 8,
    parameter int ROW_SIZE    = 28,
    parameter int COLUMN_SIZE = 28
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [DATA_SIZE-1:0]                         pixel_in,
    input  logic                                         pixel_in_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
    output logic                                         window_valid,
    output logic                                         frame_done
);

    localparam int C_NLB   = KERNEL_SIZE - 1;
    localparam int C_COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int C_ROW_W = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;

    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(ROW_SIZE - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(COLUMN_SIZE - 1);
    localparam logic [C_COL_W-1:0] C_COL_MIN  = C_COL_W'(KERNEL_SIZE - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_MIN  = C_ROW_W'(KERNEL_SIZE - 1);

    // Position of the pixel that will be accepted next.
    logic [C_COL_W-1:0] col_q, col_d;
    logic [C_ROW_W-1:0] row_q, row_d;

    // Window register, indexed [row][column]; [0][0] is top-left. Packing
    // this way makes element r*K+c land at bits (r*K+c)*DATA_SIZE.
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_SIZE-1:0] win_q, win_d;

    logic window_valid_q;
    logic frame_done_q;

    // Line-buffer read data: entry n holds the pixel from n+1 rows above.
    logic [C_NLB-1:0][DATA_SIZE-1:0]       w_lb_rd;
    // Incoming right-hand column of the window, top (oldest row) first.
    logic [KERNEL_SIZE-1:0][DATA_SIZE-1:0] w_new_col;

    logic w_last_col;
    logic w_last_row;
    logic w_in_image;

    assign w_last_col = (col_q == C_COL_LAST);
    assign w_last_row = (row_q == C_ROW_LAST);
    assign w_in_image = (row_q >= C_ROW_MIN) && (col_q >= C_COL_MIN);

    // Each buffer is a circular RAM addressed by column: reading the slot
    // about to be overwritten yields the same column one row earlier, and
    // that evicted value cascades into the next buffer.
    generate
        for (genvar n = 0; n < C_NLB; n++) begin : g_lb
            logic [DATA_SIZE-1:0] mem_q [ROW_SIZE];
            logic [DATA_SIZE-1:0] w_wr;

            if (n == 0) begin : g_head
                assign w_wr = pixel_in;
            end else begin : g_tail
                assign w_wr = w_lb_rd[n-1];
            end

            assign w_lb_rd[n] = mem_q[col_q];

            // RAM write on every accepted pixel; contents deliberately not reset.
            always_ff @(posedge clk) begin
                if (pixel_in_valid) begin
                    mem_q[col_q] <= w_wr;
                end
            end
        end
    endgenerate

    generate
        for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_col
            if (r == KERNEL_SIZE - 1) begin : g_live
                assign w_new_col[r] = pixel_in;
            end else begin : g_buf
                assign w_new_col[r] = w_lb_rd[KERNEL_SIZE-2-r];
            end
        end
    endgenerate

    // Raster position counters: column wraps into row, row wraps at frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_in_valid) begin
            if (w_last_col) begin
                col_d = '0;
                row_d = w_last_row ? '0 : row_q + C_ROW_W'(1);
            end else begin
                col_d = col_q + C_COL_W'(1);
            end
        end
    end

    // Window shifts left by one column per accepted pixel.
    always_comb begin
        win_d = win_q;
        if (pixel_in_valid) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL_SIZE-1] = w_new_col[r];
            end
        end
    end

    // State and output registers; async reset clears everything but the RAMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q          <= '0;
            row_q          <= '0;
            win_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            win_q          <= win_d;
            window_valid_q <= pixel_in_valid && w_in_image;
            frame_done_q   <= pixel_in_valid && w_last_col && w_last_row;
        end
    end

    assign window_out   = win_q;
    assign window_valid = window_valid_q;
    assign frame_done   = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sliding_window_buffer.sv
// ============================================================================
//  Module      : tb_sliding_window_buffer
//  Description : Directed bench for sliding_window_buffer with a table of
//                hand-computed windows and a ramp-image reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sliding_window_buffer;

    localparam int K  = 3;
    localparam int D  = 8;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int WB = K * K * D;

    logic          clk = 1'b0;
    logic          rst;
    logic [D-1:0]  pixel_in;
    logic          pixel_in_valid;
    logic [WB-1:0] window_out;
    logic          window_valid;
    logic          frame_done;

    always #5 clk = ~clk;

    sliding_window_buffer #(
        .KERNEL_SIZE (K),
        .DATA_SIZE   (D),
        .ROW_SIZE    (W),
        .COLUMN_SIZE (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .frame_done     (frame_done)
    );

    typedef struct packed {
        logic          sel;
        logic [7:0]    r;
        logic [7:0]    c;
        logic          v;
        logic [WB-1:0] w;
    } vec_t;

    localparam int NTBL = 8;
    vec_t tbl [NTBL];

    int n_pass  = 0;
    int n_total = 0;
    int mrow, mcol, cur_sel, nv, nd;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t row=%0d col=%0d)",
                      name, act, exp, $time, mrow, mcol);
    endtask

    function automatic logic [7:0] pix(input int sel, input int r, input int c);
        int v;
        v = (r * W + c) % 256;
        return (sel != 0) ? 8'(255 - v) : 8'(v);
    endfunction

    function automatic logic [WB-1:0] exp_win(input int sel, input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
                w[(rr*K+cc)*D +: D] = pix(sel, r - K + 1 + rr, c - K + 1 + cc);
        return w;
    endfunction

    // One clock: drive at negedge, check just after the following posedge.
    task automatic step(input logic v, input logic [7:0] d);
        logic          ev, ed;
        logic [WB-1:0] ew;
        @(negedge clk);
        pixel_in_valid = v;
        pixel_in       = d;
        ev = v && (mrow >= K - 1) && (mcol >= K - 1);
        ed = v && (mrow == H - 1) && (mcol == W - 1);
        ew = ev ? exp_win(cur_sel, mrow, mcol) : '0;
        @(posedge clk);
        #1;
        chk("window_valid", WB'(window_valid), WB'(ev));
        if (ev) chk("window_out", window_out, ew);
        chk("frame_done", WB'(frame_done), WB'(ed));
        if (v) begin
            for (int i = 0; i < NTBL; i++) begin
                if (int'(tbl[i].sel) == cur_sel && int'(tbl[i].r) == mrow && int'(tbl[i].c) == mcol) begin
                    chk("tbl_valid", WB'(window_valid), WB'(tbl[i].v));
                    if (tbl[i].v) chk("tbl_window", window_out, tbl[i].w);
                end
            end
        end
        if (window_valid) nv++;
        if (frame_done)   nd++;
        if (v) begin
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol = mcol + 1;
            end
        end
    endtask

    task automatic stream_frame(input int sel, input int duty);
        cur_sel = sel;
        nv = 0;
        nd = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (duty < 100) begin
                    int k;
                    k = 0;
                    while ($urandom_range(0, 99) >= duty && k < 10) begin
                        step(1'b0, 8'($urandom));
                        k++;
                    end
                end
                step(1'b1, pix(sel, r, c));
            end
        end
        chk("strobe_count", WB'(nv), WB'((W - K + 1) * (H - K + 1)));
        chk("frame_done_count", WB'(nd), WB'(1));
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'd2,  8'd2,  1'b1,
                   {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0}};
        tbl[1] = '{1'b0, 8'd3,  8'd0,  1'b0, {WB{1'b0}}};
        tbl[2] = '{1'b0, 8'd3,  8'd1,  1'b0, {WB{1'b0}}};
        tbl[3] = '{1'b0, 8'd3,  8'd2,  1'b1,
                   {8'd86, 8'd85, 8'd84, 8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28}};
        tbl[4] = '{1'b0, 8'd27, 8'd27, 1'b1,
                   {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213}};
        tbl[5] = '{1'b0, 8'd2,  8'd1,  1'b0, {WB{1'b0}}};
        tbl[6] = '{1'b0, 8'd1,  8'd27, 1'b0, {WB{1'b0}}};
        tbl[7] = '{1'b1, 8'd2,  8'd2,  1'b1,
                   {8'd197, 8'd198, 8'd199, 8'd225, 8'd226, 8'd227, 8'd253, 8'd254, 8'd255}};

        mrow = 0; mcol = 0; cur_sel = 0; nv = 0; nd = 0;
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in = '0;
        #2;
        chk("reset_window_out", window_out, '0);
        chk("reset_window_valid", WB'(window_valid), '0);
        chk("reset_frame_done", WB'(frame_done), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Continuous ramp frame, then idle cycles to see frame_done drop.
        stream_frame(0, 100);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Same frame with ~40% input duty.
        stream_frame(0, 40);
        step(1'b0, 8'h00);

        // Partial frame, async reset mid row 10 between clock edges.
        cur_sel = 0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, pix(0, r, c));
        for (int c = 0; c < 14; c++)
            step(1'b1, pix(0, 10, c));
        chk("pre_reset_valid", WB'(window_valid), WB'(1));
        #1 rst = 1'b1;
        #1;
        chk("async_rst_window_out", window_out, '0);
        chk("async_rst_window_valid", WB'(window_valid), '0);
        chk("async_rst_frame_done", WB'(frame_done), '0);
        #1 rst = 1'b0;
        mrow = 0;
        mcol = 0;

        // Fresh frame after reset, then an inverted frame back-to-back.
        stream_frame(0, 100);
        stream_frame(1, 100);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
